// File: rtl/outport_rr_arbiter.sv
// Round-robin output-port arbiter for the wormhole router: locks one input buffer per packet and forwards its flits.
// Optional OUTARB_PKT_CNT_EN adds a 16-bit count of forwarded packet tails on pkt_count.
module outport_rr_arbiter #(
   parameter int num_inports  = 5,
   parameter int flit_size    = 2,
   parameter int phit_size    = 16,
   parameter int log2_inports = 3
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [num_inports-1:0]                     req,
   input  logic [num_inports*flit_size*phit_size-1:0] in_data,
   input  logic [num_inports-1:0]                     in_head,
   input  logic [num_inports-1:0]                     in_tail,
   input  logic                                       dn_stop,
   output logic [num_inports-1:0]                     want,
   output logic [flit_size*phit_size-1:0]             out_data,
   output logic                                       out_new,
   output logic                                       out_head,
   output logic                                       out_tail,
   output logic [log2_inports-1:0]                    grant_id,
`ifdef OUTARB_PKT_CNT_EN
   output logic [15:0]                                pkt_count,
`endif
   output logic                                       busy
);

   localparam int flit_w_c = flit_size * phit_size;
   localparam logic [log2_inports-1:0] idx_zero_c = {log2_inports{1'b0}};
   localparam logic [log2_inports-1:0] idx_one_c  = {{(log2_inports-1){1'b0}}, 1'b1};
   localparam logic [log2_inports-1:0] idx_last_c = log2_inports'(num_inports - 1);

   typedef enum logic {ARB = 1'b0, STREAM = 1'b1} state_t;

   state_t                  state_r;
   logic [log2_inports-1:0] rr_ptr_r;
   logic                    pop_d_r;
   logic                    hit_s;
   logic                    hit_hi_s;
   logic [log2_inports-1:0] win_lo_s;
   logic [log2_inports-1:0] win_hi_s;
   logic [log2_inports-1:0] winner_s;
   logic [log2_inports-1:0] next_ptr_s;
   logic [flit_w_c-1:0]     sel_data_s;
   logic                    sel_head_s;
   logic                    sel_tail_s;
   logic                    tail_seen_s;

   // Round-robin search: lowest request at or above rr_ptr, else lowest request overall (wrap).
   always_comb begin
      hit_s    = 1'b0;
      hit_hi_s = 1'b0;
      win_lo_s = idx_zero_c;
      win_hi_s = idx_zero_c;
      for (int k = num_inports - 1; k >= 0; k--) begin
         hit_s    = hit_s | req[k];
         win_lo_s = req[k] ? log2_inports'(k) : win_lo_s;
         hit_hi_s = hit_hi_s | (req[k] & (log2_inports'(k) >= rr_ptr_r));
         win_hi_s = (req[k] & (log2_inports'(k) >= rr_ptr_r)) ? log2_inports'(k) : win_hi_s;
      end
      winner_s   = hit_hi_s ? win_hi_s : win_lo_s;
      next_ptr_s = (winner_s == idx_last_c) ? idx_zero_c : (winner_s + idx_one_c);
   end

   // Select the locked input's buffer outputs.
   always_comb begin
      sel_data_s = {flit_w_c{1'b0}};
      sel_head_s = 1'b0;
      sel_tail_s = 1'b0;
      for (int k = 0; k < num_inports; k++) begin
         sel_data_s = (grant_id == log2_inports'(k)) ? in_data[k*flit_w_c +: flit_w_c] : sel_data_s;
         sel_head_s = (grant_id == log2_inports'(k)) ? in_head[k] : sel_head_s;
         sel_tail_s = (grant_id == log2_inports'(k)) ? in_tail[k] : sel_tail_s;
      end
      tail_seen_s = pop_d_r & sel_tail_s;
   end

   // Pop strobe for the locked input; suppressed once the tail has been seen so the next packet stays put.
   always_comb begin
      want = {num_inports{1'b0}};
      for (int k = 0; k < num_inports; k++) begin
         want[k] = ~reset & (state_r == STREAM) & (grant_id == log2_inports'(k)) &
                   req[k] & ~dn_stop & ~tail_seen_s;
      end
   end

   assign busy = (state_r == STREAM) & ~reset;

   // Lock FSM, pop delay and output flit register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ARB;
         rr_ptr_r <= idx_zero_c;
         pop_d_r  <= 1'b0;
         grant_id <= idx_zero_c;
         out_data <= {flit_w_c{1'b0}};
         out_new  <= 1'b0;
         out_head <= 1'b0;
         out_tail <= 1'b0;
      end else begin
         pop_d_r <= |want;
         if (pop_d_r) begin
            out_data <= sel_data_s;
            out_head <= sel_head_s;
            out_tail <= sel_tail_s;
            out_new  <= 1'b1;
         end else begin
            out_new  <= 1'b0;
         end
         case (state_r)
            ARB: begin
               if (hit_s) begin
                  grant_id <= winner_s;
                  rr_ptr_r <= next_ptr_s;
                  state_r  <= STREAM;
               end else begin
                  state_r  <= ARB;
               end
            end
            STREAM: begin
               if (tail_seen_s) begin
                  state_r <= ARB;
               end else begin
                  state_r <= STREAM;
               end
            end
            default: state_r <= ARB;
         endcase
      end
   end

`ifdef OUTARB_PKT_CNT_EN
   // Count forwarded tails from the registered output flags; wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_count <= 16'd0;
      end else if (out_new & out_tail) begin
         pkt_count <= pkt_count + 16'd1;
      end else begin
         pkt_count <= pkt_count;
      end
   end
`endif

endmodule

// File: tb/tb_outport_rr_arbiter.sv
// Directed self-checking bench for outport_rr_arbiter with a small registered-output FIFO model per input.
module tb_outport_rr_arbiter;

   logic          clk;
   logic          reset;
   logic [4:0]    req;
   logic [159:0]  in_data;
   logic [4:0]    in_head;
   logic [4:0]    in_tail;
   logic          dn_stop;
   logic [4:0]    want;
   logic [31:0]   out_data;
   logic          out_new;
   logic          out_head;
   logic          out_tail;
   logic [2:0]    grant_id;
   logic          busy;
`ifdef OUTARB_PKT_CNT_EN
   logic [15:0]   pkt_count;
`endif

   int n_checks;
   int n_fail;

   logic [33:0] mem [5][16];
   logic [3:0]  wr_ptr [5];
   logic [3:0]  rd_ptr [5];
   logic [31:0] buf_data [5];
   logic [4:0]  block_s;

   outport_rr_arbiter #(
      .num_inports(5), .flit_size(2), .phit_size(16), .log2_inports(3)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .in_data(in_data),
      .in_head(in_head), .in_tail(in_tail), .dn_stop(dn_stop), .want(want),
      .out_data(out_data), .out_new(out_new), .out_head(out_head),
      .out_tail(out_tail), .grant_id(grant_id),
`ifdef OUTARB_PKT_CNT_EN
      .pkt_count(pkt_count),
`endif
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream buffers: non-empty drives req, a pop loads the front entry onto the registered outputs.
   always_comb begin
      req     = 5'b00000;
      in_data = 160'h0;
      for (int k = 0; k < 5; k++) begin
         req[k] = (wr_ptr[k] != rd_ptr[k]) & ~block_s[k];
         in_data[k*32 +: 32] = buf_data[k];
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 5; k++) begin
         if (reset) begin
            rd_ptr[k]   <= wr_ptr[k];
            buf_data[k] <= 32'h0;
            in_head[k]  <= 1'b0;
            in_tail[k]  <= 1'b0;
         end else if (want[k]) begin
            in_head[k]  <= mem[k][rd_ptr[k]][33];
            in_tail[k]  <= mem[k][rd_ptr[k]][32];
            buf_data[k] <= mem[k][rd_ptr[k]][31:0];
            rd_ptr[k]   <= rd_ptr[k] + 4'd1;
         end
      end
   end

   task automatic push(input int k, input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         mem[k][wr_ptr[k]] = {(i == 0), (i == n - 1), base + 32'(i)};
         wr_ptr[k] = wr_ptr[k] + 4'd1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (want !== 5'b00000) begin n_fail++; $display("FAIL reset_want: got %b exp 00000", want); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
      n_checks++; if (out_new !== 1'b0) begin n_fail++; $display("FAIL reset_out_new: got %b exp 0", out_new); end
      n_checks++; if ({out_head, out_tail} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b exp 00", {out_head, out_tail}); end
      n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h exp 0", out_data); end
      n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_grant: got %0d exp 0", grant_id); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b exp 0", busy); end
   endtask

   task automatic test_single_packet();
      logic [4:0] ew;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c == 0) push(2, 4, 32'h2000_0000);
         #1;
         ew = (c >= 1 && c <= 4) ? 5'b00100 : 5'b00000;
         n_checks++; if (want !== ew) begin n_fail++; $display("FAIL single_want c%0d: got %b exp %b", c, want, ew); end
         n_checks++; if (busy !== (c >= 1 && c <= 5)) begin n_fail++; $display("FAIL single_busy c%0d: got %b", c, busy); end
         n_checks++; if (out_new !== (c >= 3 && c <= 6)) begin n_fail++; $display("FAIL single_out_new c%0d: got %b", c, out_new); end
         if (c >= 1) begin
            n_checks++; if (grant_id !== 3'd2) begin n_fail++; $display("FAIL single_grant c%0d: got %0d exp 2", c, grant_id); end
         end
         if (c >= 3 && c <= 6) begin
            n_checks++; if (out_data !== 32'h2000_0000 + 32'(c - 3)) begin n_fail++; $display("FAIL single_data c%0d: got %h exp %h", c, out_data, 32'h2000_0000 + 32'(c - 3)); end
            n_checks++; if ({out_head, out_tail} !== {(c == 3), (c == 6)}) begin n_fail++; $display("FAIL single_flags c%0d: got %b", c, {out_head, out_tail}); end
         end
      end
   endtask

   task automatic test_round_robin();
      int          order [6];
      logic [31:0] rr_data [6];
      logic [4:0]  ew;
      order   = '{0, 1, 2, 3, 4, 0};
      rr_data = '{32'h3000_0000, 32'h3000_0010, 32'h3000_0020, 32'h3000_0030, 32'h3000_0040, 32'h3000_0001};
      do_reset();
      for (int c = 0; c < 19; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 0) begin
            push(0, 1, 32'h3000_0000);
            push(0, 1, 32'h3000_0001);
            for (int k = 1; k < 5; k++) push(k, 1, 32'h3000_0000 + 32'(k * 16));
         end
         #1;
         ew = (c % 3 == 1) ? (5'b00001 << order[(c - 1) / 3]) : 5'b00000;
         n_checks++; if (want !== ew) begin n_fail++; $display("FAIL rr_want c%0d: got %b exp %b", c, want, ew); end
         if (c % 3 == 1) begin
            n_checks++; if (grant_id !== 3'(order[(c - 1) / 3])) begin n_fail++; $display("FAIL rr_grant c%0d: got %0d exp %0d", c, grant_id, order[(c - 1) / 3]); end
         end
         n_checks++; if (out_new !== (c >= 3 && c % 3 == 0)) begin n_fail++; $display("FAIL rr_out_new c%0d: got %b", c, out_new); end
         if (c >= 3 && c % 3 == 0) begin
            n_checks++; if (out_data !== rr_data[c / 3 - 1]) begin n_fail++; $display("FAIL rr_data c%0d: got %h exp %h", c, out_data, rr_data[c / 3 - 1]); end
         end
      end
   endtask

   task automatic test_wormhole_hold();
      logic [12:0] w1_v, w0_v, eb_v, en_v;
      logic [31:0] ed [5];
      logic [4:0]  ew;
      int          di;
      w1_v = 13'b0000011000110;
      w0_v = 13'b0010000000000;
      eb_v = 13'b0110111111110;
      en_v = 13'b1001100011000;
      ed   = '{32'h4100_0000, 32'h4100_0001, 32'h4100_0002, 32'h4100_0003, 32'h4000_0001};
      di   = 0;
      do_reset();
      push(0, 1, 32'h4000_0000);
      repeat (5) @(negedge clk);
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         block_s[1] = (c >= 3 && c <= 5);
         if (c == 0) begin
            push(1, 4, 32'h4100_0000);
            push(0, 1, 32'h4000_0001);
         end
         #1;
         ew = {3'b000, w1_v[c], w0_v[c]};
         n_checks++; if (want !== ew) begin n_fail++; $display("FAIL hold_want c%0d: got %b exp %b", c, want, ew); end
         n_checks++; if (grant_id !== ((c >= 1 && c <= 9) ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL hold_grant c%0d: got %0d", c, grant_id); end
         n_checks++; if (busy !== eb_v[c]) begin n_fail++; $display("FAIL hold_busy c%0d: got %b exp %b", c, busy, eb_v[c]); end
         n_checks++; if (out_new !== en_v[c]) begin n_fail++; $display("FAIL hold_out_new c%0d: got %b exp %b", c, out_new, en_v[c]); end
         if (en_v[c]) begin
            n_checks++; if (out_data !== ed[di]) begin n_fail++; $display("FAIL hold_data c%0d: got %h exp %h", c, out_data, ed[di]); end
            n_checks++; if ({out_head, out_tail} !== {(di == 0 || di == 4), (di == 3 || di == 4)}) begin n_fail++; $display("FAIL hold_flags c%0d: got %b", c, {out_head, out_tail}); end
            di++;
         end
      end
      block_s = 5'b00000;
   endtask

   task automatic test_downstream_stall();
      logic [13:0] ds_v, w4_v, eb_v, en_v;
      logic [31:0] ed [7];
      int          di;
      ds_v = 14'b00001000011000;
      w4_v = 14'b00100111100110;
      eb_v = 14'b01101111111110;
      en_v = 14'b10011110011000;
      ed   = '{32'h5400_0000, 32'h5400_0001, 32'h5400_0002, 32'h5400_0003, 32'h5400_0004, 32'h5400_0005, 32'h5400_0010};
      di   = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         dn_stop = ds_v[c];
         if (c == 0) begin
            push(4, 6, 32'h5400_0000);
            push(4, 1, 32'h5400_0010);
         end
         #1;
         n_checks++; if (want !== {w4_v[c], 4'b0000}) begin n_fail++; $display("FAIL stall_want c%0d: got %b exp %b", c, want, {w4_v[c], 4'b0000}); end
         n_checks++; if (busy !== eb_v[c]) begin n_fail++; $display("FAIL stall_busy c%0d: got %b exp %b", c, busy, eb_v[c]); end
         n_checks++; if (out_new !== en_v[c]) begin n_fail++; $display("FAIL stall_out_new c%0d: got %b exp %b", c, out_new, en_v[c]); end
         if (en_v[c]) begin
            n_checks++; if (out_data !== ed[di]) begin n_fail++; $display("FAIL stall_data c%0d: got %h exp %h", c, out_data, ed[di]); end
            n_checks++; if ({out_head, out_tail} !== {(di == 0 || di == 6), (di == 5 || di == 6)}) begin n_fail++; $display("FAIL stall_flags c%0d: got %b", c, {out_head, out_tail}); end
            di++;
         end
      end
      dn_stop = 1'b0;
   endtask

   task automatic test_reset_mid_packet();
      @(negedge clk);
      push(3, 4, 32'h6300_0000);
      @(negedge clk);
      #1;
      n_checks++; if (want !== 5'b01000) begin n_fail++; $display("FAIL midrst_pre_want: got %b exp 01000", want); end
      n_checks++; if (grant_id !== 3'd3) begin n_fail++; $display("FAIL midrst_pre_grant: got %0d exp 3", grant_id); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++; if (want !== 5'b00000) begin n_fail++; $display("FAIL midrst_cycle_want: got %b exp 00000", want); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_cycle_busy: got %b exp 0", busy); end
      @(negedge clk);
      reset = 1'b0;
      push(1, 1, 32'h6100_0000);
      push(4, 1, 32'h6400_0000);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b exp 0", busy); end
      n_checks++; if (want !== 5'b00000) begin n_fail++; $display("FAIL midrst_want: got %b exp 00000", want); end
      n_checks++; if (out_new !== 1'b0) begin n_fail++; $display("FAIL midrst_out_new: got %b exp 0", out_new); end
      n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL midrst_grant: got %0d exp 0", grant_id); end
      n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL midrst_out_data: got %h exp 0", out_data); end
      @(negedge clk);
      #1;
      n_checks++; if (want !== 5'b00010) begin n_fail++; $display("FAIL midrst_first_want: got %b exp 00010", want); end
      n_checks++; if (grant_id !== 3'd1) begin n_fail++; $display("FAIL midrst_first_grant: got %0d exp 1", grant_id); end
      repeat (8) @(negedge clk);
   endtask

`ifdef OUTARB_PKT_CNT_EN
   task automatic test_pkt_count();
      do_reset();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 0) begin
            push(0, 1, 32'h7000_0000);
            push(1, 1, 32'h7100_0000);
            push(2, 1, 32'h7200_0000);
         end
         #1;
         if (c == 0) begin
            n_checks++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL pkt_count_reset: got %0d exp 0", pkt_count); end
         end
         if (c == 9) begin
            n_checks++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL pkt_count_two: got %0d exp 2", pkt_count); end
         end
         if (c == 11) begin
            n_checks++; if (pkt_count !== 16'd3) begin n_fail++; $display("FAIL pkt_count_three: got %0d exp 3", pkt_count); end
         end
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      dn_stop  = 1'b0;
      block_s  = 5'b00000;
      for (int k = 0; k < 5; k++) wr_ptr[k] = 4'd0;
      test_reset();
      test_single_packet();
      test_round_robin();
      test_wormhole_hold();
      test_downstream_stall();
      test_reset_mid_packet();
`ifdef OUTARB_PKT_CNT_EN
      test_pkt_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
